// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RISC-V load/store at a time against a
// word-wide data memory. Loads are lane-extracted and sign/zero-extended;
// SB/SH are done as read-modify-write because the memory only writes
// whole words. Responses are a single-cycle pulse with no back-pressure.
module load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ST_RD = 3'd2,
        ST_WR = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic        write_r;
    logic [31:0] wdata_r;
    logic [31:0] merge_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic        accept_s;
    logic        req_err_s;

    // Illegal size code for the direction, or (when checking) a misaligned H/W.
    function automatic logic req_error(input logic w, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (w) begin
            case (f3)
                3'b000, 3'b001, 3'b010: bad = 1'b0;
                default:                bad = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b011, 3'b110, 3'b111: bad = 1'b1;
                default:                bad = 1'b0;
            endcase
        end
        if (CHECK_ALIGN) begin
            if ((f3[1:0] == 2'b01) && a[0]) begin
                bad = 1'b1;
            end else if ((f3 == 3'b010) && (a != 2'b00)) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Pick the addressed lane out of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the target byte/half lane of an existing word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [31:0] res;
        res = word;
        if (f3[1:0] == 2'b00) begin
            case (a)
                2'd0:    res[7:0]   = wd[7:0];
                2'd1:    res[15:8]  = wd[7:0];
                2'd2:    res[23:16] = wd[7:0];
                2'd3:    res[31:24] = wd[7:0];
                default: res        = word;
            endcase
        end else begin
            if (a[1]) begin
                res[31:16] = wd[15:0];
            end else begin
                res[15:0] = wd[15:0];
            end
        end
        return res;
    endfunction

    assign accept_s  = req_valid && (state_r == IDLE);
    assign req_err_s = req_error(req_write, req_funct3, req_addr[1:0]);

    // Next-state selection for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (req_err_s) begin
                        state_s = RESP;
                    end else if (!req_write) begin
                        state_s = LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD:    state_s = RESP;
            ST_RD:   state_s = ST_WR;
            ST_WR:   state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus request latches and captured read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            addr_r   <= 32'h0000_0000;
            funct3_r <= 3'b000;
            write_r  <= 1'b0;
            wdata_r  <= 32'h0000_0000;
            merge_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                addr_r   <= req_addr;
                funct3_r <= req_funct3;
                write_r  <= req_write;
                wdata_r  <= req_wdata;
                err_r    <= req_err_s;
                rdata_r  <= 32'h0000_0000;
            end else if (state_r == LOAD) begin
                rdata_r <= load_extract(mem_dout, funct3_r, addr_r[1:0]);
            end else if (state_r == ST_RD) begin
                merge_r <= mem_dout;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Outputs decoded purely from registered state, so reset clears them at once.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0000_0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_din    = 32'h0000_0000;
        mem_addr   = {addr_r[31:2], 2'b00};
        case (state_r)
            IDLE:  req_ready = 1'b1;
            LOAD:  mem_read  = 1'b1;
            ST_RD: mem_read  = 1'b1;
            ST_WR: begin
                mem_write = 1'b1;
                if (funct3_r == 3'b010) begin
                    mem_din = wdata_r;
                end else begin
                    mem_din = store_merge(merge_r, wdata_r, funct3_r, addr_r[1:0]);
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_r;
                resp_rdata = rdata_r;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // write_r is kept for debug visibility of the accepted request.
    logic unused_s;
    assign unused_s = write_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one DUT with alignment checking and a
// second with it disabled, each backed by a small word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write;

    logic        req_valid1, req_ready1, req_write1;
    logic [2:0]  req_funct31;
    logic [31:0] req_addr1, req_wdata1;
    logic        resp_valid1, resp_err1;
    logic [31:0] resp_rdata1, mem_addr1, mem_din1, mem_dout1;
    logic        mem_read1, mem_write1;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int resp_cnt = 0;
    logic [31:0] last_din = 32'h0;
    logic both_seen = 1'b0;
    logic overlap = 1'b0;
    logic din_bad = 1'b0;

    load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout)
    );

    load_store_unit #(.CHECK_ALIGN(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_funct3(req_funct31), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_err(resp_err1), .resp_rdata(resp_rdata1),
        .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_read(mem_read1),
        .mem_write(mem_write1), .mem_dout(mem_dout1)
    );

    assign mem_dout  = mem0[mem_addr[7:2]];
    assign mem_dout1 = mem1[mem_addr1[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: whole-word write on posedge.
    always @(posedge clk) begin
        if (mem_write) mem0[mem_addr[7:2]] <= mem_din;
        if (mem_write1) mem1[mem_addr1[7:2]] <= mem_din1;
    end

    // Protocol monitor on DUT0, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) begin
            wr_cnt++;
            last_din = mem_din;
        end
        if (mem_read && mem_write) both_seen = 1'b1;
        if (resp_valid) resp_cnt++;
        if (resp_valid && req_ready) overlap = 1'b1;
        if (!mem_write && (mem_din != 32'h0)) din_bad = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on DUT0; called just after a negedge with DUT0 idle.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
        bit got;
        got = 1'b0;
        rd = 32'h0; er = 1'b0; lat = 99;
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            if (!got && resp_valid) begin
                got = 1'b1;
                lat = i;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    // Issue one request on DUT1 (alignment checks disabled).
    task automatic do_req1(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat);
        bit got;
        got = 1'b0;
        rd = 32'h0; er = 1'b0; lat = 99;
        req_write1 = w; req_funct31 = f3; req_addr1 = a; req_wdata1 = wd;
        req_valid1 = 1'b1;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            if (!got && resp_valid1) begin
                got = 1'b1;
                lat = i;
                rd = resp_rdata1;
                er = resp_err1;
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        logic [0:5]  aw;
        logic [31:0] aa [0:5];
        logic [31:0] ad [0:5];

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_funct31 = 3'b000;
        req_addr1 = 32'h0; req_wdata1 = 32'h0;

        // Reset state
        #12;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

        // SW then LW at 0x10
        do_req(1'b1, 3'b010, 32'h10, 32'h8badf00d, rd, er, lat);
        chk("sw_lat", lat, 32'd2);
        chk("sw_err", {31'b0, er}, 32'h0);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_wr_cnt", wr_cnt, 32'd1);
        chk("sw_rd_cnt", rd_cnt, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        chk("lw_lat", lat, 32'd2);
        chk("lw_rdata", rd, 32'h8badf00d);

        // Sub-word loads from 0x80ff7f01 at 0x20
        do_req(1'b1, 3'b010, 32'h20, 32'h80ff7f01, rd, er, lat);
        do_req(1'b0, 3'b000, 32'h21, 32'h0, rd, er, lat);
        chk("lb_21", rd, 32'h0000007f);
        do_req(1'b0, 3'b000, 32'h22, 32'h0, rd, er, lat);
        chk("lb_22", rd, 32'hffffffff);
        do_req(1'b0, 3'b100, 32'h23, 32'h0, rd, er, lat);
        chk("lbu_23", rd, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, rd, er, lat);
        chk("lh_22", rd, 32'hffff80ff);
        do_req(1'b0, 3'b101, 32'h20, 32'h0, rd, er, lat);
        chk("lhu_20", rd, 32'h00007f01);
        chk("lhu_err", {31'b0, er}, 32'h0);

        // Read-modify-write stores at 0x30
        do_req(1'b1, 3'b010, 32'h30, 32'h11223344, rd, er, lat);
        do_req(1'b1, 3'b000, 32'h31, 32'haaaaaa55, rd, er, lat);
        chk("sb_lat", lat, 32'd3);
        chk("sb_rd_cnt", rd_cnt, 32'd1);
        chk("sb_wr_cnt", wr_cnt, 32'd1);
        chk("sb_din", last_din, 32'h11225544);
        chk("sb_rdata", rd, 32'h0);
        do_req(1'b1, 3'b001, 32'h32, 32'h0000beef, rd, er, lat);
        chk("sh_lat", lat, 32'd3);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
        chk("sh_word", rd, 32'hbeef5544);

        // Error responses with alignment checking
        do_req(1'b1, 3'b010, 32'h40, 32'hdeadbeef, rd, er, lat);
        do_req(1'b0, 3'b010, 32'h41, 32'h0, rd, er, lat);
        chk("lw_mis_err", {31'b0, er}, 32'h1);
        chk("lw_mis_lat", lat, 32'd1);
        chk("lw_mis_rdata", rd, 32'h0);
        chk("lw_mis_mem", rd_cnt + wr_cnt, 32'd0);
        do_req(1'b1, 3'b001, 32'h43, 32'h00001234, rd, er, lat);
        chk("sh_mis_err", {31'b0, er}, 32'h1);
        chk("sh_mis_lat", lat, 32'd1);
        chk("sh_mis_mem", rd_cnt + wr_cnt, 32'd0);
        do_req(1'b0, 3'b011, 32'h40, 32'h0, rd, er, lat);
        chk("f3_011_err", {31'b0, er}, 32'h1);
        chk("f3_011_lat", lat, 32'd1);
        chk("f3_011_mem", rd_cnt + wr_cnt, 32'd0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
        chk("err_mem_kept", rd, 32'hdeadbeef);

        // No alignment checking: LW 0x41 returns the word at 0x40
        do_req1(1'b1, 3'b010, 32'h40, 32'hcafe1234, rd, er, lat);
        do_req1(1'b0, 3'b010, 32'h41, 32'h0, rd, er, lat);
        chk("na_lw_err", {31'b0, er}, 32'h0);
        chk("na_lw_lat", lat, 32'd2);
        chk("na_lw_rdata", rd, 32'hcafe1234);

        // Asynchronous reset during ST_WR of an SB
        do_req(1'b1, 3'b010, 32'h50, 32'h12345678, rd, er, lat);
        req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h50; req_wdata = 32'h000000aa;
        req_valid = 1'b1;
        resp_cnt = 0; wr_cnt = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("rw_in_st_wr", {31'b0, mem_write}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rw_async_drop", {31'b0, mem_write}, 32'h0);
        chk("rw_din_zero", mem_din, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_ready", {31'b0, req_ready}, 32'h1);
        chk("rw_word_kept", mem0[20], 32'h12345678);
        chk("rw_no_write", wr_cnt, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rw_no_resp", resp_cnt, 32'd0);

        // Held req_valid with alternating LW/SB
        do_req(1'b1, 3'b010, 32'h60, 32'h0, rd, er, lat);
        aw = 6'b010101;
        aa[0] = 32'h60; aa[1] = 32'h60; aa[2] = 32'h60;
        aa[3] = 32'h61; aa[4] = 32'h60; aa[5] = 32'h62;
        ad[0] = 32'h0;  ad[1] = 32'h11; ad[2] = 32'h0;
        ad[3] = 32'h22; ad[4] = 32'h0;  ad[5] = 32'h33;
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
        both_seen = 1'b0; overlap = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_write = aw[k];
            req_funct3 = aw[k] ? 3'b000 : 3'b010;
            req_addr = aa[k];
            req_wdata = ad[k];
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("alt_ready_bound", {31'b0, req_ready}, 32'h1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("alt_resp_cnt", resp_cnt, 32'd6);
        chk("alt_wr_cnt", wr_cnt, 32'd3);
        chk("alt_rd_cnt", rd_cnt, 32'd6);
        chk("alt_overlap", {31'b0, overlap}, 32'h0);
        do_req(1'b0, 3'b010, 32'h60, 32'h0, rd, er, lat);
        chk("alt_word", rd, 32'h00332211);

        chk("never_both", {31'b0, both_seen}, 32'h0);
        chk("din_idle_zero", {31'b0, din_bad}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
